// File: rtl/adder_stats_pkg.sv
// Shared types and default sizing for the adder error-statistics collector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_stats_pkg;

    // Collector phases: gathering a window, or holding its results.
    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } stats_state_t;

    localparam int N_DEF = 16;
    localparam int W_DEF = 4;

endpackage

// File: rtl/adder_error_stats_if.sv
// Sample-in and window-results-out bundle of the adder error-statistics collector.
// Latency: none (wiring only).
// Backpressure: in_ready throttles samples, res_ready releases window results.
interface adder_error_stats_if
    import adder_stats_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     x;
    logic [N-1:0]     y;
    logic [N-1:0]     s_apx;
    logic             co_apx;

    logic             res_valid;
    logic             res_ready;
    logic [W:0]       res_err_cnt;
    logic [N+W:0]     res_sum_ed;
    logic [N:0]       res_max_ed;
    logic [N:0]       res_med;

    // Sample producer and results consumer side.
    modport master (
        output in_valid, x, y, s_apx, co_apx, res_ready,
        input  in_ready, res_valid, res_err_cnt, res_sum_ed, res_max_ed, res_med
    );

    // Collector side.
    modport slave (
        input  in_valid, x, y, s_apx, co_apx, res_ready,
        output in_ready, res_valid, res_err_cnt, res_sum_ed, res_max_ed, res_med
    );

endinterface

// File: rtl/adder_ed_calc.sv
// Error distance between the exact sum and an approximate adder's {co,s} result.
// Latency: combinational.
// Backpressure: none.
module adder_ed_calc #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] s_apx,
    input  logic         co_apx,
    output logic [N:0]   ed,
    output logic         err
);

    logic [N:0] exact;
    logic [N:0] apx;

    // Subtract the smaller from the larger so overestimates give a positive distance.
    always_comb begin
        exact = {1'b0, x} + {1'b0, y};
        apx   = {co_apx, s_apx};
        if (exact >= apx) begin
            ed = exact - apx;
        end else begin
            ed = apx - exact;
        end
        err = (ed != '0);
    end

endmodule

// File: rtl/adder_error_stats.sv
// Windowed error statistics (count, ED sum, max ED, MED) of an approximate adder stream.
// Latency: results valid 2 cycles after the window's last sample is accepted.
// Backpressure: in_ready drops once the window is full and stays low until res_ready.
module adder_error_stats
    import adder_stats_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_error_stats_if.slave   bus
);

    localparam logic [W:0] WIN = (W+1)'(2**W);

    stats_state_t state;
    logic [W:0]   acc_cnt;
    logic         s1_vld;
    logic [N:0]   s1_ed;
    logic         s1_err;
    logic [W:0]   err_cnt;
    logic [N+W:0] sum_ed;
    logic [N:0]   max_ed;

    logic [N:0]   ed;
    logic         err;
    logic         accept;

    adder_ed_calc #(.N(N)) u_ed_calc (
        .x      (bus.x),
        .y      (bus.y),
        .s_apx  (bus.s_apx),
        .co_apx (bus.co_apx),
        .ed     (ed),
        .err    (err)
    );

    // Handshake flags come from registered state only, so there is no input-to-output path.
    assign bus.in_ready  = (state == ACCUM) && (acc_cnt != WIN);
    assign bus.res_valid = (state == REPORT);
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.res_err_cnt = err_cnt;
    assign bus.res_sum_ed  = sum_ed;
    assign bus.res_max_ed  = max_ed;
    assign bus.res_med     = sum_ed[N+W:W];

    // Stage 1: capture the error distance of each accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_ed  <= '0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_ed  <= ed;
                s1_err <= err;
            end
        end
    end

    // Window FSM with sample counter and stage-2 accumulators; the full counter
    // blocks further accepts, so stage 1 only ever holds samples of this window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            acc_cnt <= '0;
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                    if (s1_vld) begin
                        err_cnt <= err_cnt + {{W{1'b0}}, s1_err};
                        sum_ed  <= sum_ed + {{W{1'b0}}, s1_ed};
                        if (s1_ed > max_ed) begin
                            max_ed <= s1_ed;
                        end
                        // Counter already full means this is the window's last sample.
                        if (acc_cnt == WIN) begin
                            state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        state   <= ACCUM;
                        acc_cnt <= '0;
                        err_cnt <= '0;
                        sum_ed  <= '0;
                        max_ed  <= '0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_error_stats.sv
// Scoreboard bench for adder_error_stats with a 4-sample window (N=16, W=2).
// Latency: checks results 2 cycles after the last accept.
// Backpressure: holds res_ready low in REPORT and confirms inputs are refused.
module tb_adder_error_stats;

    localparam int N = 16;
    localparam int W = 2;

    typedef struct packed {
        logic [W:0]   cnt;
        logic [N+W:0] sum;
        logic [N:0]   max;
        logic [N:0]   med;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    adder_error_stats_if #(.N(N), .W(W)) bus ();

    adder_error_stats #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one sample and wait for its accept; returns the accept cycle.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] apx, output int acc_cyc);
        bit done;
        done = 1'b0;
        acc_cyc = -1;
        bus.in_valid = 1'b1;
        bus.x = a;
        bus.y = b;
        {bus.co_apx, bus.s_apx} = apx;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                if (bus.in_ready) done = 1'b1;
                @(posedge clk);
                #1;
                if (done) acc_cyc = cyc;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Called at t+1 after the last accept in t; checks throughput and result latency.
    task automatic finish_window(input int first_cyc, input int last_cyc);
        bus.res_ready = 1'b0;
        chk("throughput", last_cyc - first_cyc, 32'd3);
        chk("valid_t1", bus.res_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("valid_t2", bus.res_valid, 1'b1);
        chk("ready_in_report", bus.in_ready, 1'b0);
        @(negedge clk);
        #1;
    endtask

    task automatic release_results();
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("rel_in_ready", bus.in_ready, 1'b1);
        chk("rel_res_valid", bus.res_valid, 1'b0);
        chk("rel_err_cnt", bus.res_err_cnt, 32'd0);
        chk("rel_sum_ed", bus.res_sum_ed, 32'd0);
        chk("rel_max_ed", bus.res_max_ed, 32'd0);
    endtask

    // Monitor: on each rising res_valid, pop the expected window and compare.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (bus.res_valid && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_err_cnt", bus.res_err_cnt, e.cnt);
                    chk("res_sum_ed", bus.res_sum_ed, e.sum);
                    chk("res_max_ed", bus.res_max_ed, e.max);
                    chk("res_med", bus.res_med, e.med);
                end
            end else if (!bus.res_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        int c0, c1, c2, c3, d;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.s_apx = '0;
        bus.co_apx = 1'b0;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_err_cnt", bus.res_err_cnt, 32'd0);
        chk("rst_sum_ed", bus.res_sum_ed, 32'd0);
        chk("rst_max_ed", bus.res_max_ed, 32'd0);
        chk("rst_med", bus.res_med, 32'd0);
        rst = 1'b0;

        // Exact window; res_ready held high during ACCUM must be ignored.
        sb_q.push_back('{cnt: 3'd0, sum: 19'd0, max: 17'd0, med: 17'd0});
        bus.res_ready = 1'b1;
        send(16'h1234, 16'h4321, 17'h05555, c0);
        send(16'hFFFF, 16'h0001, 17'h10000, c1);
        send(16'hAAAA, 16'h5555, 17'h0FFFF, c2);
        chk("early_valid", bus.res_valid, 1'b0);
        send(16'h8000, 16'h8000, 17'h10000, c3);
        finish_window(c0, c3);
        release_results();

        // Mixed errors: ED 1,1,2,0.
        sb_q.push_back('{cnt: 3'd3, sum: 19'd4, max: 17'd2, med: 17'd1});
        send(16'h00FF, 16'h00FF, 17'h001FF, c0);
        send(16'hFFFF, 16'hFFFF, 17'h1FFFF, c1);
        send(16'h8001, 16'h0101, 17'h08100, c2);
        send(16'h0001, 16'h0001, 17'h00002, c3);
        finish_window(c0, c3);

        // Backpressure in REPORT with a sample offered every cycle.
        bus.in_valid = 1'b1;
        bus.x = 16'h0000;
        bus.y = 16'h0000;
        {bus.co_apx, bus.s_apx} = 17'h00007;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_res_valid", bus.res_valid, 1'b1);
            chk("bp_sum_ed", bus.res_sum_ed, 32'd4);
            chk("bp_err_cnt", bus.res_err_cnt, 32'd3);
        end
        release_results();

        // Overestimate: apx above the exact sum by the full range.
        sb_q.push_back('{cnt: 3'd1, sum: 19'h1FFFF, max: 17'h1FFFF, med: 17'h07FFF});
        send(16'h0000, 16'h0000, 17'h1FFFF, c0);
        send(16'h0010, 16'h0020, 17'h00030, c1);
        send(16'h7000, 16'h9000, 17'h10000, c2);
        send(16'h0003, 16'h0004, 17'h00007, c3);
        finish_window(c0, c3);
        release_results();

        // Reset mid-window discards the partial window.
        send(16'h0000, 16'h0000, 17'h00005, d);
        send(16'h0000, 16'h0000, 17'h00005, d);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        chk("mid_rst_sum_ed", bus.res_sum_ed, 32'd0);
        chk("mid_rst_err_cnt", bus.res_err_cnt, 32'd0);
        sb_q.push_back('{cnt: 3'd0, sum: 19'd0, max: 17'd0, med: 17'd0});
        send(16'h0102, 16'h0304, 17'h00406, c0);
        send(16'h1111, 16'h2222, 17'h03333, c1);
        send(16'hF000, 16'h1000, 17'h10000, c2);
        chk("mid_rst_early_valid", bus.res_valid, 1'b0);
        send(16'h0000, 16'h0000, 17'h00000, c3);
        finish_window(c0, c3);
        release_results();

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_error_stats.md
# adder_error_stats

Streaming error-statistics collector that sits directly downstream of the approximate adders (HOERAA and siblings). Each accepted sample carries the adder's operands and its approximate result. The block computes the exact sum internally and the error distance (ED). Over a fixed power-of-two window it accumulates error count, ED sum, maximum ED and mean ED (MED), then presents the window's results through a valid/ready handshake.

## Interface
- `N`, default 16: adder operand width.
- `W`, default 4: log2 of window length; window holds `2**W` samples.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: sample present.
- `in_ready` output, 1 bit: block can accept a sample.
- `x` input, N bits: adder operand X.
- `y` input, N bits: adder operand Y.
- `s_apx` input, N bits: approximate sum S from the adder under test.
- `co_apx` input, 1 bit: approximate carry-out Co.
- `res_valid` output, 1 bit: window results available.
- `res_ready` input, 1 bit: consumer takes the results.
- `res_err_cnt` output, W+1 bits: samples with ED ≠ 0.
- `res_sum_ed` output, N+1+W bits: sum of ED.
- `res_max_ed` output, N+1 bits: maximum ED.
- `res_med` output, N+1 bits: `res_sum_ed >> W`, truncated.

## Operation
- Sample accepted on any cycle with `in_valid && in_ready`.
- Exact sum: `{1'b0,x} + {1'b0,y}`, N+1 bits. Approximate sum: `{co_apx,s_apx}`, N+1 bits.
- ED = |exact − apx|, unsigned, N+1 bits. The result must be correct when apx > exact.
- Stage 1 register: holds ED plus a valid bit.
- Stage 2 accumulators, updated from stage 1:
  - `err_cnt += (ED≠0)`
  - `sum_ed += ED`
  - `max_ed = max(max_ed, ED)`
- No saturation is needed; the widths cover the worst case exactly.
- `acc_cnt`, W+1 bits, counts accepted samples in the current window.
- Two-state FSM:
  - ACCUM: `in_ready = (acc_cnt != 2**W)`.
  - ACCUM → REPORT: when stage 1 holds the window's last sample, that sample is accumulated in the same edge.
  - REPORT: `in_ready = 0`, `res_valid = 1`, all `res_*` stable.
  - REPORT → ACCUM: on `res_ready`. The same edge clears `acc_cnt` and all accumulators to 0.
- `res_*` outputs are driven directly from the accumulators. They are qualified only by `res_valid`.
- `res_ready` in ACCUM is ignored. `in_valid` while `in_ready=0` is ignored; no sample is captured.
- Reset:
  - State ACCUM; `in_ready = 1`, `res_valid = 0`.
  - All counters, accumulators and `res_*` = 0; stage-1 valid = 0.
- Reset mid-window discards the partial window, including any sample in stage 1.
- Reset during REPORT drops the pending results.

## Timing
- `in_ready` and `res_valid` are Moore outputs, decoded from registered state and `acc_cnt` only. There are no combinational paths from inputs to outputs.
- Throughput: one sample per cycle during ACCUM.
- Latency, last sample accepted in cycle t:
  - Stage 1 loads at the end of t.
  - Accumulate and ACCUM→REPORT at the end of t+1.
  - `res_valid = 1` from cycle t+2.
- Handshake with `res_ready=1` in cycle r: ACCUM and `in_ready = 1` from r+1.
- Minimum window period: `2**W + 2` cycles.
- In-flight rule: `acc_cnt` stops the window at exactly `2**W` samples. Stage 1 can never hold a sample belonging to the next window.

## Structure
- Package `adder_stats_pkg`:
  - State typedef `stats_state_t` {ACCUM, REPORT}.
  - Default constants `N_DEF = 16`, `W_DEF = 4`.
- Combinational sub-module `adder_ed_calc` (N parameter): x, y, s_apx, co_apx → ed, err. The same sub-module is reused by the offline error-metric benches.
- Top `adder_error_stats` holds the stage-1 register, accumulators, `acc_cnt` and FSM.

## Test plan
Benches use N=16, W=2 (4-sample window) and drive `s_apx`/`co_apx` directly.
- **Reset:** assert `rst` 2 cycles → `in_ready=1`, `res_valid=0`, all `res_*=0`.
- **Exact window:** 4 samples with apx = x+y → `res_err_cnt=0`, `res_sum_ed=0`, `res_max_ed=0`, `res_med=0`. `res_valid` rises 2 cycles after the 4th accept.
- **Mixed errors:** four samples, then check the window results.
  - x=y=0x00FF, apx 0x001FF (ED 1).
  - x=y=0xFFFF, apx 0x1FFFF (ED 1).
  - x=0x8001, y=0x0101, apx 0x08100 (ED 2).
  - x=y=0x0001, apx 0x00002 (ED 0).
  - Required: `err_cnt=3`, `sum_ed=4`, `max_ed=2`, `med=1`.
- **Overestimate:** x=y=0, apx 0x1FFFF, then 3 exact samples → `max_ed=0x1FFFF`, `sum_ed=0x1FFFF`, `med=0x7FFF`, `err_cnt=1`.
- **Backpressure:** hold `res_ready=0` for 5 cycles in REPORT with `in_valid=1` → `in_ready=0`, `res_*` unchanged, no sample counted. Pulse `res_ready` → next cycle `in_ready=1`, accumulators 0.
- **Reset mid-window:** 2 samples with ED 5, then `rst`, then 4 exact samples → results all 0; `res_valid` only after the 4th post-reset accept.
